// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, buffer
// geometry, reset fetch address and the buffered entry layout.
package fetch_pkg;

  localparam int unsigned FETCH_AW    = 16;
  localparam int unsigned FETCH_DW    = 16;
  localparam int unsigned FETCH_DEPTH = 2;

  localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = 16'h0000;

  // IDLE: no request in flight; REQ: request in flight, data wanted;
  // DROP: request in flight, data to be discarded after a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // One buffered instruction and the word address it was fetched from.
  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps FFFF -> 0000.
  function automatic logic [FETCH_AW-1:0] pc_next(input logic [FETCH_AW-1:0] pc);
    return pc + FETCH_AW'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decoder-side signals.
//   master : fetch unit (drives mem_req/mem_addr and the decoder outputs)
//   slave  : environment (memory, branch unit, decoder)
interface instruction_fetch_if import fetch_pkg::*;;

  logic                mem_req;
  logic [FETCH_AW-1:0] mem_addr;
  logic                mem_ack;
  logic [FETCH_DW-1:0] mem_data;
  logic                stall;
  logic                branch_en;
  logic [FETCH_AW-1:0] branch_target;
  logic [FETCH_DW-1:0] instruct;
  logic                instr_valid;
  logic [FETCH_AW-1:0] pc_out;

  modport master (
    output mem_req, mem_addr, instruct, instr_valid, pc_out,
    input  mem_ack, mem_data, stall, branch_en, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, instruct, instr_valid, pc_out,
    output mem_ack, mem_data, stall, branch_en, branch_target
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO. Slot 0 is always the head, so the head data
// and valid come straight from flops. Head data is only overwritten when a
// new valid entry lands in slot 0, so it holds its last value while empty.
// Ports:
//   clock, reset      : clock, async active-high reset
//   push, push_entry  : write one entry (ignored when full)
//   pop               : drop the head (ignored when empty)
//   flush             : empty the FIFO; wins over push and pop
//   count             : number of valid entries (0..2)
//   head, head_valid  : oldest entry and its valid flag
module fetch_buffer import fetch_pkg::*; (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         head_valid
);

  fetch_entry_t e0_q, e0_n, e1_q, e1_n;
  logic         v0_q, v0_n, v1_q, v1_n;
  logic         do_pop, do_push;

  // Entry and valid registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      e0_q <= e0_n;
      e1_q <= e1_n;
      v0_q <= v0_n;
      v1_q <= v1_n;
    end
  end

  // Pop first (shift slot 1 down), then place the push in the first free slot
  always_comb begin
    e0_n    = e0_q;
    e1_n    = e1_q;
    v0_n    = v0_q;
    v1_n    = v1_q;
    do_pop  = pop & v0_q;
    do_push = push & (~v1_q | do_pop);

    if (flush) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end else begin
      if (do_pop) begin
        if (v1_q) begin
          e0_n = e1_q;
          v0_n = 1'b1;
          v1_n = 1'b0;
        end else begin
          v0_n = 1'b0;
        end
      end
      if (do_push) begin
        if (!v0_n) begin
          e0_n = push_entry;
          v0_n = 1'b1;
        end else begin
          e1_n = push_entry;
          v1_n = 1'b1;
        end
      end
    end
  end

  assign count      = 2'(v0_q) + 2'(v1_q);
  assign head       = e0_q;
  assign head_valid = v0_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues single-outstanding word reads to an
// instruction memory that answers with data in the ack cycle, buffers up to
// two returned words and presents the oldest to the decoder. A branch
// flushes the buffer, redirects fetch, and discards any in-flight read.
// Ports:
//   clock, reset          : clock, async active-high reset
//   bus.mem_req/mem_addr  : read request and word address (registered)
//   bus.mem_ack/mem_data  : request accepted, instruction word
//   bus.stall             : decoder does not consume this cycle
//   bus.branch_en/target  : fetch redirect
//   bus.instruct/pc_out   : head instruction and its word address
//   bus.instr_valid       : head valid
module instruction_fetch import fetch_pkg::*; #(
  parameter logic [FETCH_AW-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned         DEPTH    = FETCH_DEPTH
) (
  input logic                 clock,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  fetch_state_e        state_q, state_n;
  logic [FETCH_AW-1:0] fetch_pc_q, fetch_pc_n;
  logic [FETCH_AW-1:0] mem_addr_q, mem_addr_n;
  logic                mem_req_q, mem_req_n;
  logic                push, flush, pop, room;
  logic [1:0]          buf_count;
  fetch_entry_t        head, push_entry;
  logic                head_valid;

  // A new request may start only when the buffer can take its data
  assign room       = 32'(buf_count) < DEPTH;
  assign pop        = head_valid & ~bus.stall;
  assign push_entry = {bus.mem_data, fetch_pc_q};

  // State and request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      mem_req_q  <= mem_req_n;
      mem_addr_q <= mem_addr_n;
    end
  end

  // Next state, fetch address and buffer control
  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    mem_req_n  = mem_req_q;
    mem_addr_n = mem_addr_q;
    push       = 1'b0;
    flush      = bus.branch_en;

    unique case (state_q)
      IDLE: begin
        if (bus.branch_en) begin
          fetch_pc_n = bus.branch_target;
        end else if (room) begin
          state_n    = REQ;
          mem_req_n  = 1'b1;
          mem_addr_n = fetch_pc_q;
        end
      end

      REQ: begin
        if (bus.branch_en) begin
          fetch_pc_n = bus.branch_target;
          if (bus.mem_ack) begin
            state_n   = IDLE;
            mem_req_n = 1'b0;
          end else begin
            // Request stays on the bus; its data is now stale
            state_n = DROP;
          end
        end else if (bus.mem_ack) begin
          push       = 1'b1;
          fetch_pc_n = pc_next(fetch_pc_q);
          state_n    = IDLE;
          mem_req_n  = 1'b0;
        end
      end

      DROP: begin
        if (bus.branch_en) begin
          fetch_pc_n = bus.branch_target;
        end
        if (bus.mem_ack) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
        end
      end

      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  fetch_buffer u_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (buf_count),
    .head       (head),
    .head_valid (head_valid)
  );

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instruct    = head.instr;
  assign bus.pc_out      = head.pc;
  assign bus.instr_valid = head_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run, all checked against a queue-based transaction model.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic clock;
  logic reset;
  logic reset_w;

  instruction_fetch_if bus ();
  instruction_fetch_if bus_w ();

  instruction_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  instruction_fetch #(.RESET_PC(16'hFFFF), .DEPTH(2)) dut_w (
    .clock (clock),
    .reset (reset_w),
    .bus   (bus_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: buffer as a queue of {instr, pc}, one in-flight read
  logic [31:0] m_q[$];
  logic [15:0] m_fetch;
  logic        m_pending;
  logic        m_discard;
  logic [15:0] m_req_addr;
  logic [31:0] m_last_head;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch     = 16'h0000;
    m_pending   = 1'b0;
    m_discard   = 1'b0;
    m_req_addr  = 16'h0000;
    m_last_head = 32'h0;
  endtask

  // One rising edge of the reference behaviour, using the inputs held over it
  task automatic model_edge(input logic ack, input logic [15:0] data, input logic st,
                            input logic br, input logic [15:0] tgt);
    int  sz;
    bit  do_pop;
    sz     = m_q.size();
    do_pop = (sz > 0) && !st;
    if (br) begin
      m_q.delete();
      m_fetch = tgt;
      if (m_pending) begin
        if (ack) begin
          m_pending = 1'b0;
          m_discard = 1'b0;
        end else begin
          m_discard = 1'b1;
        end
      end
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (m_pending) begin
        if (ack) begin
          if (!m_discard) begin
            m_q.push_back({data, m_fetch});
            m_fetch = m_fetch + 16'd1;
          end
          m_pending = 1'b0;
          m_discard = 1'b0;
        end
      end else if (sz < 2) begin
        m_pending  = 1'b1;
        m_req_addr = m_fetch;
      end
    end
    if (m_q.size() > 0) m_last_head = m_q[0];
  endtask

  task automatic check_model(input string tag);
    check({tag, ".req"}, 16'(bus.mem_req), 16'(m_pending));
    if (m_pending) check({tag, ".addr"}, bus.mem_addr, m_req_addr);
    check({tag, ".valid"}, 16'(bus.instr_valid), 16'(m_q.size() > 0));
    check({tag, ".instr"}, bus.instruct, m_last_head[31:16]);
    check({tag, ".pc"}, bus.pc_out, m_last_head[15:0]);
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input logic ack, input logic [15:0] data, input logic st,
                      input logic br, input logic [15:0] tgt);
    bus.mem_ack       = ack;
    bus.mem_data      = data;
    bus.stall         = st;
    bus.branch_en     = br;
    bus.branch_target = tgt;
    model_edge(ack, data, st, br, tgt);
    @(posedge clock);
    #1;
    check_model("step");
    @(negedge clock);
  endtask

  // Called at a falling edge; holds reset with ack asserted, returns released
  task automatic apply_reset(input int edges);
    reset         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_data  = 16'($urandom);
    bus.branch_en = 1'b0;
    bus.stall     = 1'b0;
    model_reset();
    #1;
    check_model("rst_now");
    check("rst_addr", bus.mem_addr, 16'h0000);
    repeat (edges) @(posedge clock);
    #1;
    check_model("rst_hold");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    reset_w              = 1'b1;
    bus.mem_ack          = 1'b0;
    bus.mem_data         = 16'h0000;
    bus.stall            = 1'b0;
    bus.branch_en        = 1'b0;
    bus.branch_target    = 16'h0000;
    bus_w.mem_ack        = 1'b1;
    bus_w.mem_data       = 16'h5A5A;
    bus_w.stall          = 1'b0;
    bus_w.branch_en      = 1'b0;
    bus_w.branch_target  = 16'h0000;
    model_reset();

    // Wrap-around instance: reset state, then FFFF -> 0000
    @(negedge clock);
    check("w_rst_req", 16'(bus_w.mem_req), 16'h0000);
    check("w_rst_addr", bus_w.mem_addr, 16'hFFFF);
    check("w_rst_instr", bus_w.instruct, 16'h0000);
    check("w_rst_pc", bus_w.pc_out, 16'h0000);
    reset_w = 1'b0;
    @(posedge clock); #1;
    check("w_e1_req", 16'(bus_w.mem_req), 16'h0001);
    check("w_e1_addr", bus_w.mem_addr, 16'hFFFF);
    @(posedge clock); #1;
    check("w_e2_valid", 16'(bus_w.instr_valid), 16'h0001);
    check("w_e2_pc", bus_w.pc_out, 16'hFFFF);
    @(posedge clock); #1;
    check("w_e3_req", 16'(bus_w.mem_req), 16'h0001);
    check("w_e3_addr", bus_w.mem_addr, 16'h0000);
    check("w_e3_hold_pc", bus_w.pc_out, 16'hFFFF);
    @(posedge clock); #1;
    check("w_e4_valid", 16'(bus_w.instr_valid), 16'h0001);
    check("w_e4_pc", bus_w.pc_out, 16'h0000);
    @(negedge clock);

    // Reset release with ack tied high and a stalled decoder
    apply_reset(2);
    step(1'b1, 16'hA123, 1'b1, 1'b0, 16'h0);
    check("rel_req0", 16'(bus.mem_req), 16'h0001);
    check("rel_addr0", bus.mem_addr, 16'h0000);
    step(1'b1, 16'hA123, 1'b1, 1'b0, 16'h0);
    check("rel_valid", 16'(bus.instr_valid), 16'h0001);
    check("rel_instr", bus.instruct, 16'hA123);
    check("rel_pc", bus.pc_out, 16'h0000);
    step(1'b1, 16'hA123, 1'b1, 1'b0, 16'h0);
    check("rel_addr1", bus.mem_addr, 16'h0001);
    // Buffer fills, requests stop
    step(1'b1, 16'hA124, 1'b1, 1'b0, 16'h0);
    step(1'b1, 16'hA125, 1'b1, 1'b0, 16'h0);
    check("full_noreq_a", 16'(bus.mem_req), 16'h0000);
    step(1'b1, 16'hA125, 1'b1, 1'b0, 16'h0);
    check("full_noreq_b", 16'(bus.mem_req), 16'h0000);
    // One consumed slot -> exactly one more request, to 0002
    step(1'b1, 16'hA126, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'hA127, 1'b1, 1'b0, 16'h0);
    check("full_req2", 16'(bus.mem_req), 16'h0001);
    check("full_addr2", bus.mem_addr, 16'h0002);
    step(1'b1, 16'hA128, 1'b1, 1'b0, 16'h0);
    step(1'b1, 16'hA129, 1'b1, 1'b0, 16'h0);
    check("full_noreq_c", 16'(bus.mem_req), 16'h0000);

    // Branch while a request at 0005 waits for its ack
    apply_reset(1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0005);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("drop_addr5", bus.mem_addr, 16'h0005);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
    check("drop_hold_req", 16'(bus.mem_req), 16'h0001);
    check("drop_hold_addr", bus.mem_addr, 16'h0005);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    check("drop_no_data", 16'(bus.instr_valid), 16'h0000);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("drop_next_addr", bus.mem_addr, 16'h0040);

    // Branch + ack + pop together with one entry buffered
    step(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("bap_valid_pre", 16'(bus.instr_valid), 16'h0001);
    check("bap_instr_pre", bus.instruct, 16'h1111);
    step(1'b1, 16'h2222, 1'b0, 1'b1, 16'h0100);
    check("bap_flush", 16'(bus.instr_valid), 16'h0000);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("bap_target", bus.mem_addr, 16'h0100);

    // Reset in the middle of an outstanding request with data buffered
    step(1'b1, 16'h3333, 1'b1, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("mid_req_pre", 16'(bus.mem_req), 16'h0001);
    apply_reset(2);
    step(1'b1, 16'h4444, 1'b1, 1'b0, 16'h0);
    check("mid_first_addr", bus.mem_addr, 16'h0000);
    check("mid_first_req", 16'(bus.mem_req), 16'h0001);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r_ack, r_st, r_br;
      logic [15:0] r_tgt;
      if ($urandom_range(0, 399) == 0) apply_reset($urandom_range(1, 2));
      r_ack = ($urandom_range(0, 9) < 5);
      r_st  = ($urandom_range(0, 9) < 4);
      r_br  = ($urandom_range(0, 99) < 6);
      r_tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                           : 16'($urandom);
      step(r_ack, 16'($urandom), r_st, r_br, r_tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries; fixed at 2 in this revision.
REQ-003 SHALL have port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port mem_req, output, 1: instruction memory read request.
REQ-006 SHALL have port mem_addr, output, 16: word address of the request.
REQ-007 SHALL have port mem_ack, input, 1: memory accepts the request and returns data in the same cycle.
REQ-008 SHALL have port mem_data, input, 16: instruction word, valid when mem_ack=1.
REQ-009 SHALL have port stall, input, 1: downstream decoder does not consume this cycle.
REQ-010 SHALL have port branch_en, input, 1: redirect fetch.
REQ-011 SHALL have port branch_target, input, 16: redirect word address.
REQ-012 SHALL have port instruct, output, 16: buffer head word; drives the decoder's instruct input.
REQ-013 SHALL have port instr_valid, output, 1: head valid; drives the decoder's enable input.
REQ-014 SHALL have port pc_out, output, 16: word address of the head instruction.

Function
REQ-015 SHALL use FSM states IDLE, REQ and DROP.
REQ-016 SHALL move IDLE->REQ on a clock edge when the buffer count < 2 and branch_en=0, with mem_req=1 and mem_addr=fetch_pc from that edge.
REQ-017 SHALL hold mem_req and mem_addr stable in REQ and DROP until mem_ack=1; at most one request is outstanding.
REQ-018 SHALL, in REQ with mem_ack=1 and branch_en=0, push {mem_data, fetch_pc} into the buffer, set fetch_pc=fetch_pc+1 (mod 2^16, wrapping FFFF->0000), deassert mem_req and return to IDLE.
REQ-019 SHALL set instr_valid=1 and instruct/pc_out to the head entry whenever the count > 0, so an ack at edge N gives instr_valid=1 after edge N+1 when the buffer was empty.
REQ-020 SHALL pop the head when instr_valid=1 and stall=0; a push and a pop in the same cycle leave the count unchanged.
REQ-021 SHALL never push when full: requests are issued only at count < 2 with one outstanding.
REQ-022 SHALL, when branch_en=1 in any state, flush the buffer (count=0, instr_valid=0 next cycle) and set fetch_pc=branch_target; the flush overrides any same-cycle push or pop.
REQ-023 SHALL, when branch_en=1 in REQ without mem_ack, go to DROP, keep the pending request, and discard its data on ack, then go to IDLE.
REQ-024 SHALL, when branch_en=1 in REQ with mem_ack=1, discard mem_data and go to IDLE.
REQ-025 SHALL, for repeated branch_en while in DROP, take the latest branch_target.
REQ-026 SHALL leave instruct and pc_out unchanged while instr_valid=0.

Reset
REQ-027 SHALL, while reset=1, force mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, instr_valid=0, instruct=16'h0000, pc_out=16'h0000, state=IDLE.
REQ-028 SHALL assert the first mem_req on the first clock edge after reset deasserts.
REQ-029 SHALL abandon an outstanding request on reset mid-transaction and ignore any mem_ack while reset=1.

Structure
REQ-030 SHALL place the FSM state typedef, DEPTH and the RESET_PC default in the shared package fetch_pkg.
REQ-031 SHALL implement the buffer as sub-module fetch_buffer: a 2-entry FIFO of {instr[15:0], pc[15:0]} with push, pop, flush, count[1:0] and head outputs.

Verification
REQ-032 SHALL cover reset release: mem_ack tied to 1 and mem_data=16'hA123 -> mem_addr sequence 0000,0001; instruct=16'hA123 with pc_out=0000 and instr_valid=1 one cycle after the first ack.
REQ-033 SHALL cover full buffer: stall=1 with immediate ack -> exactly two requests (0000, 0001), then mem_req=0; releasing stall for one cycle -> exactly one new request, to 0002.
REQ-034 SHALL cover branch during wait: mem_req pending at 0005 with ack delayed 3 cycles, branch_en for one cycle with target 0040 -> DROP; the returned data is not presented; the next request goes to 0040.
REQ-035 SHALL cover simultaneous branch+ack+pop: count=1 -> next cycle instr_valid=0 and the next request goes to the target.
REQ-036 SHALL cover wrap-around: RESET_PC=FFFF -> request addresses FFFF then 0000; pc_out follows them.
REQ-037 SHALL cover mid-transaction reset: reset pulsed while mem_req=1 -> mem_req=0 and count=0 immediately; the first request after release goes to RESET_PC.
